spi_master: RTL

Single-clock SPI master that drives the slave-side `spi_wrapper` frame protocol: SS_n framing, a mode-select bit, a 10-bit command/payload word MSB first, and for read-data commands an 8-bit MISO capture. It replaces hand-written bench stimulus in the RAM-over-SPI subsystem and is the initiator a host controller instantiates to reach the slave's memory.

---
 rtl/spi_pkg.sv | 22 ++
 rtl/spi_master_if.sv | 26 ++
 rtl/spi_master.sv | 158 +++++++++++++++
 3 files changed

// File: rtl/spi_pkg.sv
// Shared definitions for the RAM-over-SPI master and slave: command
// encodings, frame geometry and the master state enum.
package spi_pkg;

    localparam int FRAME_W = 10;
    localparam int DATA_W  = 8;

    localparam logic [1:0] CMD_WR_ADDR = 2'b00;
    localparam logic [1:0] CMD_WR_DATA = 2'b01;
    localparam logic [1:0] CMD_RD_ADDR = 2'b10;
    localparam logic [1:0] CMD_RD_DATA = 2'b11;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SEL,
        ST_SHIFT,
        ST_WAIT,
        ST_READ,
        ST_GAP
    } mst_state_t;

endpackage

// File: rtl/spi_master_if.sv
// Host request/response handshake plus the serial SPI lines of the master.
interface spi_master_if;
    import spi_pkg::*;

    logic              start;
    logic [1:0]        cmd;
    logic [DATA_W-1:0] din;
    logic              busy;
    logic              done;
    logic [DATA_W-1:0] rd_data;
    logic              rd_valid;
    logic              MOSI;
    logic              MISO;
    logic              SS_n;

    modport master (
        input  start, cmd, din, MISO,
        output busy, done, rd_data, rd_valid, MOSI, SS_n
    );

    modport slave (
        output start, cmd, din, MISO,
        input  busy, done, rd_data, rd_valid, MOSI, SS_n
    );

endinterface

// File: rtl/spi_master.sv
// SPI master driving the spi_wrapper frame: SS_n framing, mode bit, 10-bit
// command/payload word MSB first, and an 8-bit MISO capture for rd-data frames.
module spi_master
    import spi_pkg::*;
#(
    parameter int RD_WAIT = 1,
    parameter int GAP     = 2
) (
    input  logic         SCK,
    input  logic         rst_n,
    spi_master_if.master bus
);

    localparam logic [3:0] WAIT_LD  = 4'(RD_WAIT - 1);
    localparam logic [3:0] SHIFT_LD = 4'(FRAME_W - 1);
    localparam logic [3:0] READ_LD  = 4'(DATA_W - 1);
    // The done edge already counts as the first GAP cycle, so GAP=1 returns straight to IDLE.
    localparam logic [3:0] GAP_LD   = 4'((GAP > 1) ? (GAP - 2) : 0);
    localparam mst_state_t END_ST   = (GAP > 1) ? ST_GAP : ST_IDLE;

    mst_state_t          state_q, state_d;
    logic [3:0]          cnt_q, cnt_d;
    logic [FRAME_W-1:0]  sr_q, sr_d;
    logic [DATA_W-1:0]   rx_q, rx_d;
    logic [DATA_W-1:0]   rd_data_q, rd_data_d;
    logic                is_rd_q, is_rd_d;
    logic                ss_n_q, ss_n_d;
    logic                mosi_q, mosi_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;
    logic                rd_valid_q, rd_valid_d;

    always_ff @(posedge SCK or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            sr_q       <= '0;
            rx_q       <= '0;
            rd_data_q  <= '0;
            is_rd_q    <= 1'b0;
            ss_n_q     <= 1'b1;
            mosi_q     <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            rd_valid_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            sr_q       <= sr_d;
            rx_q       <= rx_d;
            rd_data_q  <= rd_data_d;
            is_rd_q    <= is_rd_d;
            ss_n_q     <= ss_n_d;
            mosi_q     <= mosi_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            rd_valid_q <= rd_valid_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        sr_d       = sr_q;
        rx_d       = rx_q;
        rd_data_d  = rd_data_q;
        is_rd_d    = is_rd_q;
        ss_n_d     = ss_n_q;
        mosi_d     = mosi_q;
        busy_d     = busy_q;
        done_d     = 1'b0;
        rd_valid_d = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (bus.start) begin
                    sr_d    = {bus.cmd, bus.din};
                    is_rd_d = (bus.cmd == CMD_RD_DATA);
                    ss_n_d  = 1'b0;
                    mosi_d  = bus.cmd[1];
                    busy_d  = 1'b1;
                    cnt_d   = 4'd1;
                    state_d = ST_SEL;
                end
            end
            ST_SEL: begin
                if (cnt_q == 4'd0) begin
                    mosi_d  = sr_q[FRAME_W-1];
                    sr_d    = {sr_q[FRAME_W-2:0], 1'b0};
                    cnt_d   = SHIFT_LD;
                    state_d = ST_SHIFT;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            ST_SHIFT: begin
                if (cnt_q != 4'd0) begin
                    mosi_d = sr_q[FRAME_W-1];
                    sr_d   = {sr_q[FRAME_W-2:0], 1'b0};
                    cnt_d  = cnt_q - 4'd1;
                end else begin
                    mosi_d = 1'b0;
                    if (is_rd_q) begin
                        cnt_d   = WAIT_LD;
                        state_d = ST_WAIT;
                    end else begin
                        ss_n_d  = 1'b1;
                        done_d  = 1'b1;
                        busy_d  = (END_ST == ST_GAP);
                        cnt_d   = GAP_LD;
                        state_d = END_ST;
                    end
                end
            end
            ST_WAIT: begin
                if (cnt_q == 4'd0) begin
                    cnt_d   = READ_LD;
                    state_d = ST_READ;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            ST_READ: begin
                rx_d = {rx_q[DATA_W-2:0], bus.MISO};
                if (cnt_q == 4'd0) begin
                    rd_data_d  = {rx_q[DATA_W-2:0], bus.MISO};
                    rd_valid_d = 1'b1;
                    done_d     = 1'b1;
                    ss_n_d     = 1'b1;
                    busy_d     = (END_ST == ST_GAP);
                    cnt_d      = GAP_LD;
                    state_d    = END_ST;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            ST_GAP: begin
                if (cnt_q == 4'd0) begin
                    busy_d  = 1'b0;
                    state_d = ST_IDLE;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign bus.SS_n     = ss_n_q;
    assign bus.MOSI     = mosi_q;
    assign bus.busy     = busy_q;
    assign bus.done     = done_q;
    assign bus.rd_data  = rd_data_q;
    assign bus.rd_valid = rd_valid_q;

endmodule
